// File: rtl/pipe_dbg_pkg.sv
// Shared definitions for the pipeline debug blocks: FSM encoding, default PC
// width and a constant-evaluable ceil(log2) helper.
package pipe_dbg_pkg;

  localparam int PC_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// DEPTH x WIDTH simple dual-port array: synchronous write, synchronous
// registered read whose output holds between reads.
module trace_ram
  import pipe_dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = PC_W_DEFAULT,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the read register is reset; array contents are don't-care.
  always_ff @(posedge clock) begin
    if (reset) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pc_trace_monitor.sv
// Captures the pipeline PC every running cycle into a circular trace, stops on
// a cycle budget or a halt (repeated PC), then drains oldest-first on request.
module pc_trace_monitor
  import pipe_dbg_pkg::*;
#(
  parameter int PC_W        = PC_W_DEFAULT,
  parameter int DEPTH       = 16,
  parameter int MAX_CYCLES  = 50,
  parameter int STALL_LIMIT = 4,
  localparam int CNT_W      = clog2(MAX_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             rd_en,
  output logic [PC_W-1:0]  rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             overflow,
  output logic             done,
  output logic             halt_detected,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int PTR_W  = clog2(DEPTH);
  localparam int OCC_W  = clog2(DEPTH + 1);
  localparam int SAME_W = clog2(STALL_LIMIT + 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SAME_W-1:0] same_q, same_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic              overflow_q, overflow_d;
  logic              halt_q, halt_d;
  logic              rd_valid_q;
  logic              ram_we, ram_re;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    cnt_d      = cnt_q;
    same_d     = same_q;
    last_pc_d  = last_pc_q;
    overflow_d = overflow_q;
    halt_d     = halt_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        ram_we    = 1'b1;
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        cnt_d     = cnt_q + CNT_W'(1);
        last_pc_d = pc_in;
        // A full buffer drops its oldest entry so the trace keeps the newest DEPTH.
        if (occ_q < OCC_W'(DEPTH)) begin
          occ_d = occ_q + OCC_W'(1);
        end else begin
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
          overflow_d = 1'b1;
        end
        if (cnt_q != '0 && pc_in == last_pc_q) same_d = same_q + SAME_W'(1);
        else same_d = '0;
        if (same_d == SAME_W'(STALL_LIMIT)) begin
          halt_d  = 1'b1;
          state_d = DONE;
        end
        if (cnt_d == CNT_W'(MAX_CYCLES)) state_d = DONE;
      end
      DONE: begin
        if (clear) begin
          state_d    = IDLE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          occ_d      = '0;
          cnt_d      = '0;
          overflow_d = 1'b0;
          halt_d     = 1'b0;
        end else if (rd_en && occ_q != '0) begin
          ram_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          occ_d    = occ_q - OCC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      cnt_q      <= '0;
      same_q     <= '0;
      last_pc_q  <= '0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      cnt_q      <= cnt_d;
      same_q     <= same_d;
      last_pc_q  <= last_pc_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
      rd_valid_q <= ram_re;
    end
  end

  trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(PC_W)
  ) u_trace_ram (
    .clock  (clock),
    .reset  (reset),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(pc_in),
    .re_i   (ram_re),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );

  assign rd_valid      = rd_valid_q;
  assign empty         = (occ_q == '0);
  assign done          = (state_q == DONE);
  assign overflow      = overflow_q;
  assign halt_detected = halt_q;
  assign cycle_count   = cnt_q;

endmodule
